// File: rtl/rc4_decrypt_core.sv
// RC4 trial-decryption core: INIT -> KSA -> PRGA -> DONE over an external S-box RAM.
// Optional early abort on first unacceptable plaintext byte: define RC4_EARLY_ABORT_EN.
module rc4_decrypt_core #(
   parameter int unsigned MSG_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic [21:0] key,
   output logic [7:0]  s_addr,
   output logic [7:0]  s_wdata,
   output logic        s_we,
   input  logic [7:0]  s_rdata,
   output logic [4:0]  rom_addr,
   input  logic [7:0]  rom_rdata,
   output logic [4:0]  msg_addr,
   output logic [7:0]  msg_wdata,
   output logic        msg_we,
   output logic        finish_decrypt,
   output logic        valid
);

   typedef enum logic [4:0] {
      ST_RST, ST_INIT,
      K_RI, K_WI, K_RJ, K_WJ, K_SI, K_SJ,
      P_RI, P_WI, P_RJ, P_WJ, P_SI, P_SJ, P_RT, P_WT, P_OUT,
      ST_DONE
   } state_t;

   state_t      state, state_next;
   logic [7:0]  i, j, si, sj, pt;
   logic [4:0]  k;
   logic [1:0]  km;
   logic [21:0] key_q;
   logic [23:0] secret;
   logic [7:0]  kb;
   logic        ok_all;
   logic        pt_ok;
   logic        last_byte;
   logic        stop;

   assign secret    = {2'b00, key_q};
   assign pt_ok     = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7A));
   assign last_byte = (k == 5'(MSG_LEN - 1));

   always_comb begin
      case (km)
         2'd0:    kb = secret[23:16];
         2'd1:    kb = secret[15:8];
         default: kb = secret[7:0];
      endcase
   end

`ifdef RC4_EARLY_ABORT_EN
   assign stop = last_byte || !pt_ok;
`else
   assign stop = last_byte;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RST;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RST:  state_next = ST_INIT;
         ST_INIT: if (i == 8'hFF) state_next = K_RI;
         K_RI:    state_next = K_WI;
         K_WI:    state_next = K_RJ;
         K_RJ:    state_next = K_WJ;
         K_WJ:    state_next = K_SI;
         K_SI:    state_next = K_SJ;
         K_SJ:    state_next = (i == 8'hFF) ? P_RI : K_RI;
         P_RI:    state_next = P_WI;
         P_WI:    state_next = P_RJ;
         P_RJ:    state_next = P_WJ;
         P_WJ:    state_next = P_SI;
         P_SI:    state_next = P_SJ;
         P_SJ:    state_next = P_RT;
         P_RT:    state_next = P_WT;
         P_WT:    state_next = P_OUT;
         P_OUT:   state_next = stop ? ST_DONE : P_RI;
         ST_DONE: state_next = ST_DONE;
         default: state_next = ST_RST;
      endcase
      if (restart) state_next = ST_INIT;
   end

   always_comb begin
      s_addr    = '0;
      s_wdata   = '0;
      s_we      = 1'b0;
      rom_addr  = '0;
      msg_addr  = '0;
      msg_wdata = '0;
      msg_we    = 1'b0;
      case (state)
         ST_INIT: begin
            s_we    = 1'b1;
            s_addr  = i;
            s_wdata = i;
         end
         K_RI:        s_addr = i;
         P_RI:        s_addr = i + 8'd1;
         K_RJ, P_RJ:  s_addr = j;
         K_SI, P_SI: begin
            s_we    = 1'b1;
            s_addr  = i;
            s_wdata = sj;
         end
         K_SJ, P_SJ: begin
            s_we    = 1'b1;
            s_addr  = j;
            s_wdata = si;
         end
         // after the swap S[i]+S[j] is still si+sj
         P_RT: begin
            s_addr   = si + sj;
            rom_addr = k;
         end
         P_OUT: begin
            msg_we    = 1'b1;
            msg_addr  = k;
            msg_wdata = pt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i              <= '0;
         j              <= '0;
         k              <= '0;
         km             <= '0;
         si             <= '0;
         sj             <= '0;
         pt             <= '0;
         key_q          <= '0;
         ok_all         <= 1'b0;
         finish_decrypt <= 1'b0;
         valid          <= 1'b0;
      end else if (restart) begin
         i              <= '0;
         j              <= '0;
         k              <= '0;
         km             <= '0;
         finish_decrypt <= 1'b0;
         valid          <= 1'b0;
      end else begin
         case (state)
            ST_RST: i <= '0;
            ST_INIT: begin
               if (i == 8'h00) key_q <= key;
               i  <= i + 8'd1;
               j  <= '0;
               km <= '0;
            end
            K_WI: begin
               si <= s_rdata;
               j  <= j + s_rdata + kb;
            end
            K_WJ, P_WJ: sj <= s_rdata;
            K_SJ: begin
               if (i == 8'hFF) begin
                  i      <= '0;
                  j      <= '0;
                  k      <= '0;
                  ok_all <= 1'b1;
               end else begin
                  i  <= i + 8'd1;
                  km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
               end
            end
            P_RI: i <= i + 8'd1;
            P_WI: begin
               si <= s_rdata;
               j  <= j + s_rdata;
            end
            P_WT: pt <= s_rdata ^ rom_rdata;
            P_OUT: begin
               ok_all <= ok_all & pt_ok;
               k      <= k + 5'd1;
               if (stop) begin
                  finish_decrypt <= 1'b1;
                  valid          <= ok_all & pt_ok;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Scoreboard bench for rc4_decrypt_core with a software RC4 reference model.
module tb_rc4_decrypt_core;
   localparam int unsigned MSG_LEN = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        restart = 1'b0;
   logic [21:0] key = '0;
   logic [7:0]  s_addr, s_wdata, s_rdata;
   logic        s_we;
   logic [4:0]  rom_addr, msg_addr;
   logic [7:0]  rom_rdata, msg_wdata;
   logic        msg_we, finish_decrypt, valid;

   rc4_decrypt_core #(.MSG_LEN(MSG_LEN)) dut (
      .clk(clk), .rst(rst), .restart(restart), .key(key),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata),
      .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .msg_addr(msg_addr), .msg_wdata(msg_wdata), .msg_we(msg_we),
      .finish_decrypt(finish_decrypt), .valid(valid)
   );

   always #5 clk = ~clk;

   logic [7:0] sram [256];
   logic [7:0] rom [32];
   logic [7:0] msgram [32];

   always @(posedge clk) begin
      if (s_we) sram[s_addr] <= s_wdata;
      s_rdata   <= sram[s_addr];
      rom_rdata <= rom[rom_addr];
      if (msg_we) msgram[msg_addr] <= msg_wdata;
   end

   int checks = 0;
   int failures = 0;

   typedef struct { logic [4:0] addr; logic [7:0] data; } exp_t;
   exp_t exp_q[$];
   exp_t e;
   int   pulses;
   int   exp_count;
   logic exp_valid;
   logic [7:0] ks [32];
   logic [7:0] pt_arr [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (s_we || msg_we)) chk("we_exclusive", {31'd0, s_we & msg_we}, 32'd0);
      if (msg_we) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL msg_unexpected actual=%h/%h required=none", msg_addr, msg_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("msg_write", {19'd0, msg_addr, msg_wdata}, {19'd0, e.addr, e.data});
         end
      end
   end

   function automatic logic acceptable(input logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   function automatic logic [7:0] rand_good();
      int unsigned r = $urandom_range(0, 26);
      return (r == 26) ? 8'h20 : 8'h61 + 8'(r);
   endfunction

   // Plain software RC4 keystream for a 3-byte key {2'b00,k}.
   task automatic compute_ks(input logic [21:0] k);
      logic [7:0] S [256];
      logic [7:0] kb [3];
      logic [7:0] ii, jj, t;
      logic [23:0] sec = {2'b00, k};
      kb[0] = sec[23:16]; kb[1] = sec[15:8]; kb[2] = sec[7:0];
      for (int n = 0; n < 256; n++) S[n] = 8'(n);
      jj = 0;
      for (int n = 0; n < 256; n++) begin
         jj = jj + S[n] + kb[n % 3];
         t = S[n]; S[n] = S[jj]; S[jj] = t;
      end
      ii = 0; jj = 0;
      for (int n = 0; n < 32; n++) begin
         ii = ii + 8'd1;
         jj = jj + S[ii];
         t = S[ii]; S[ii] = S[jj]; S[jj] = t;
         ks[n] = S[8'(S[ii] + S[jj])];
      end
   endtask

   task automatic prepare(input logic [21:0] k);
      logic stopped = 1'b0;
      compute_ks(k);
      exp_q.delete();
      exp_count = 0;
      exp_valid = 1'b1;
      pulses    = 0;
      for (int n = 0; n < int'(MSG_LEN); n++) begin
         rom[n] = pt_arr[n] ^ ks[n];
         if (!stopped) begin
            exp_q.push_back('{addr: 5'(n), data: pt_arr[n]});
            exp_count++;
         end
         if (!acceptable(pt_arr[n])) begin
            exp_valid = 1'b0;
`ifdef RC4_EARLY_ABORT_EN
            stopped = 1'b1;
`endif
         end
      end
   endtask

   task automatic pulse_restart(input logic [21:0] k);
      @(negedge clk);
      key = k;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_state", {19'd0, finish_decrypt, valid, s_we, s_addr, s_wdata},
          {19'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0});
   endtask

   task automatic wait_finish(input int change_at);
      int n = 0;
      while (n < 6000 && !finish_decrypt) begin
         @(negedge clk);
         if (n == change_at) key = 22'($urandom);
         n++;
      end
      chk("finish_timeout", {31'd0, finish_decrypt}, 32'd1);
      chk("valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("pulse_count", 32'(pulses), 32'(exp_count));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      for (int m = 0; m < exp_count; m++) chk("msg_ram", {24'd0, msgram[m]}, {24'd0, pt_arr[m]});
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         chk("done_hold", {29'd0, finish_decrypt, s_we, msg_we}, {29'd0, 1'b1, 1'b0, 1'b0});
      end
   endtask

   initial begin
      // First trial runs straight out of reset: key 1, 32 x 'a'.
      for (int n = 0; n < 32; n++) pt_arr[n] = 8'h61;
      prepare(22'h000001);
      key = 22'h000001;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {4'd0, s_addr, s_wdata, s_we, rom_addr, msg_addr, msg_wdata, msg_we, finish_decrypt, valid}, 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         chk("init_seq", {14'd0, finish_decrypt, s_we, s_addr, s_wdata}, {14'd0, 1'b0, 1'b1, 8'(c), 8'(c)});
      end
      wait_finish(-1);

      // Restart out of DONE with valid=1, random key and acceptable text.
      for (int n = 0; n < 32; n++) pt_arr[n] = rand_good();
      begin
         logic [21:0] k2 = 22'($urandom);
         prepare(k2);
         pulse_restart(k2);
      end
      wait_finish(-1);

      // Bad first byte.
      pt_arr[0] = 8'h23;
      for (int n = 1; n < 32; n++) pt_arr[n] = 8'h61;
      prepare(22'h000001);
      pulse_restart(22'h000001);
      wait_finish(-1);

      // Abandon a trial 400 cycles into KSA, restart with key 2.
      for (int n = 0; n < 32; n++) pt_arr[n] = 8'h61;
      prepare(22'h000001);
      pulse_restart(22'h000001);
      repeat (256 + 400) @(negedge clk);
      for (int n = 0; n < 32; n++) pt_arr[n] = rand_good();
      prepare(22'h000002);
      pulse_restart(22'h000002);
      wait_finish(-1);

      // Key input changes mid-PRGA; latched key must be used.
      for (int n = 0; n < 32; n++) pt_arr[n] = rand_good();
      prepare(22'h000003);
      pulse_restart(22'h000003);
      wait_finish(1900);

      // Random trials, some with a stray unacceptable byte.
      for (int t = 0; t < 6; t++) begin
         logic [21:0] kr = 22'($urandom);
         for (int n = 0; n < 32; n++) pt_arr[n] = rand_good();
         if (t % 2 == 1) pt_arr[$urandom_range(0, 31)] = 8'h41;
         prepare(kr);
         pulse_restart(kr);
         wait_finish(-1);
      end

      // Asynchronous reset in the middle of INIT.
      pulse_restart(22'h000005);
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {4'd0, s_addr, s_wdata, s_we, rom_addr, msg_addr, msg_wdata, msg_we, finish_decrypt, valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
